// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared encodings for the instruction/data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    // Access size encodings on the mmu port
    localparam logic [1:0] SZ_BYTE = 2'h0;
    localparam logic [1:0] SZ_HALF = 2'h1;
    localparam logic [1:0] SZ_WORD = 2'h2;

    // Arbiter state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Owner of the transaction currently on the mmu port
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Read data returned to the owner when the watchdog aborts
    localparam logic [31:0] ABORT_PATTERN = 32'hDEAD_BEEF;

    // Latched copy of the granted request, driven straight onto the mmu port
    typedef struct packed {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
        logic [1:0]  size;
    } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Requester-side and mmu-side signals of the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;

    // Instruction-fetch requester
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;

    // Load/store requester
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_done;
    logic [31:0] d_rdata;

    // mmu port
    logic [31:0] m_address;
    logic        m_rw_req;
    logic        m_rw;
    logic [31:0] m_write_data;
    logic [1:0]  m_size;
    logic [31:0] m_read_data;
    logic        m_data_valid;
    logic        m_busy;

    logic        timeout_err;

    // Arbiter view: serves the requesters and drives the mmu request
    modport slave (
        input  i_req, i_addr,
        output i_done, i_rdata,
        input  d_req, d_rw, d_addr, d_wdata, d_size,
        output d_done, d_rdata,
        output m_address, m_rw_req, m_rw, m_write_data, m_size,
        input  m_read_data, m_data_valid, m_busy,
        output timeout_err
    );

    // Environment view: requesters plus the mmu responder
    modport master (
        output i_req, i_addr,
        input  i_done, i_rdata,
        output d_req, d_rw, d_addr, d_wdata, d_size,
        input  d_done, d_rdata,
        input  m_address, m_rw_req, m_rw, m_write_data, m_size,
        output m_read_data, m_data_valid, m_busy,
        input  timeout_err
    );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_starve_ctr.sv
// ============================================================================
// Module      : arb_starve_ctr
// Description : Saturating counter of data grants made while fetch waits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_inc,
    output logic      o_limit_hit
);

    localparam int c_width = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [c_width-1:0] c_limit = c_width'(LIMIT);

    logic [c_width-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_limit_hit = (r_count >= c_limit);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one mmu port between instruction fetch and load/store,
//               with data priority, starvation bound and a hang watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 1023
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_arbiter_if.slave  bus
);

    localparam int c_wdog_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(TIMEOUT - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_owner;
    mem_req_t            r_req;
    mem_req_t            w_req_nxt;
    logic                r_rw_req;
    logic [c_wdog_w-1:0] r_wdog;
    logic                r_i_done;
    logic                r_d_done;
    logic [31:0]         r_i_rdata;
    logic [31:0]         r_d_rdata;
    logic                r_timeout_err;

    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_complete;
    logic                w_abort;
    logic                w_limit_hit;
    logic [31:0]         w_rdata;

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk         (clk),
        .rst         (reset),
        .i_clr       (w_grant_i || (w_grant_d && !bus.i_req)),
        .i_inc       (w_grant_d && bus.i_req),
        .o_limit_hit (w_limit_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Data wins unless fetch has been held off STARVE_LIMIT times
                w_grant_d = bus.d_req && !(bus.i_req && w_limit_hit);
                w_grant_i = bus.i_req && !w_grant_d;
                if (w_grant_d || w_grant_i) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A genuine completion outranks a coincident watchdog expiry
                if (bus.m_data_valid) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end else if (r_wdog == c_wdog_last) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!bus.m_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        if (w_grant_d) begin
            w_req_nxt = '{addr: bus.d_addr, rw: bus.d_rw, wdata: bus.d_wdata, size: bus.d_size};
        end else begin
            w_req_nxt = '{addr: bus.i_addr, rw: 1'b0, wdata: 32'h0, size: SZ_WORD};
        end
    end

    assign w_rdata = w_complete ? bus.m_read_data : ABORT_PATTERN;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner       <= OWN_I;
            r_req         <= '0;
            r_rw_req      <= 1'b0;
            r_wdog        <= '0;
            r_i_done      <= 1'b0;
            r_d_done      <= 1'b0;
            r_i_rdata     <= '0;
            r_d_rdata     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_i_done      <= 1'b0;
            r_d_done      <= 1'b0;
            r_timeout_err <= 1'b0;

            if (w_grant_d || w_grant_i) begin
                r_req    <= w_req_nxt;
                r_rw_req <= 1'b1;
                r_owner  <= w_grant_d ? OWN_D : OWN_I;
                r_wdog   <= '0;
            end

            if (r_state == ST_GRANT) begin
                r_wdog <= r_wdog + 1'b1;
            end

            if (w_complete || w_abort) begin
                r_rw_req      <= 1'b0;
                r_timeout_err <= w_abort;
                if (r_owner == OWN_D) begin
                    r_d_done  <= 1'b1;
                    r_d_rdata <= w_rdata;
                end else begin
                    r_i_done  <= 1'b1;
                    r_i_rdata <= w_rdata;
                end
            end
        end
    end

    assign bus.m_address    = r_req.addr;
    assign bus.m_rw         = r_req.rw;
    assign bus.m_write_data = r_req.wdata;
    assign bus.m_size       = r_req.size;
    assign bus.m_rw_req     = r_rw_req;
    assign bus.i_done       = r_i_done;
    assign bus.i_rdata      = r_i_rdata;
    assign bus.d_done       = r_d_done;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.timeout_err  = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int c_starve = 4;
    localparam int c_timeout = 16;
    localparam logic [31:0] c_i_base = 32'h0000_0400;
    localparam logic [31:0] c_d_base = 32'h0000_0500;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .STARVE_LIMIT (c_starve),
        .TIMEOUT      (c_timeout)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and park on the following falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    // Called right after the grant edge; mmu raises valid so it is sampled lat edges later
    task automatic serve(input int lat, input logic [31:0] rdata);
        bus.m_busy = 1'b1;
        for (int i = 1; i < lat; i++) tick();
        bus.m_data_valid = 1'b1;
        bus.m_read_data  = rdata;
        tick();
        bus.m_data_valid = 1'b0;
        bus.m_busy       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int seen;
        logic [31:0] exp_addr;
        logic exp_d;

        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.i_req = 1'b0;  bus.i_addr = '0;
        bus.d_req = 1'b0;  bus.d_rw = 1'b0;  bus.d_addr = '0;
        bus.d_wdata = '0;  bus.d_size = 2'h0;
        bus.m_read_data = '0;  bus.m_data_valid = 1'b0;  bus.m_busy = 1'b0;

        tick(); tick(); tick();
        check_val("rst_rw_req", bus.m_rw_req, 0);
        check_val("rst_addr", bus.m_address, 0);
        check_val("rst_dones", {bus.i_done, bus.d_done, bus.timeout_err}, 0);
        reset = 1'b0;
        tick();

        // Single D word write
        bus.d_req = 1'b1;  bus.d_rw = 1'b1;  bus.d_addr = 32'h0001_0040;
        bus.d_wdata = 32'h1234_5678;  bus.d_size = 2'h2;
        tick();
        check_val("dw_rw_req", bus.m_rw_req, 1);
        check_val("dw_addr", bus.m_address, 32'h0001_0040);
        check_val("dw_wdata", bus.m_write_data, 32'h1234_5678);
        check_val("dw_rw_size", {bus.m_rw, bus.m_size}, 3'b110);
        bus.d_addr = 32'hFFFF_0000;
        serve(4, 32'h0);
        check_val("dw_done", {bus.d_done, bus.i_done}, 2'b10);
        check_val("dw_rw_req_low", bus.m_rw_req, 0);
        check_val("dw_addr_frozen", bus.m_address, 32'h0001_0040);
        bus.d_req = 1'b0;
        tick();
        check_val("dw_done_pulse", bus.d_done, 0);

        // Single I fetch
        bus.i_req = 1'b1;  bus.i_addr = 32'h0000_0100;
        tick();
        check_val("if_addr", bus.m_address, 32'h0000_0100);
        check_val("if_rw_size", {bus.m_rw_req, bus.m_rw, bus.m_size}, 4'b1010);
        serve(2, 32'h0000_0013);
        check_val("if_done", {bus.i_done, bus.d_done}, 2'b10);
        check_val("if_rdata", bus.i_rdata, 32'h0000_0013);
        bus.i_req = 1'b0;
        tick();

        // Simultaneous requests: D first, then I
        bus.i_req = 1'b1;  bus.i_addr = 32'h0000_0200;
        bus.d_req = 1'b1;  bus.d_rw = 1'b0;  bus.d_addr = 32'h0000_0300;  bus.d_size = 2'h0;
        tick();
        check_val("sim_first_d", bus.m_address, 32'h0000_0300);
        check_val("sim_starve1", dut.u_starve_ctr.r_count, 1);
        serve(2, 32'h0000_00AA);
        check_val("sim_d_done", {bus.d_done, bus.i_done}, 2'b10);
        check_val("sim_d_rdata", bus.d_rdata, 32'h0000_00AA);
        bus.d_req = 1'b0;
        tick();
        tick();
        check_val("sim_second_i", {bus.m_rw_req, bus.m_address}, {1'b1, 32'h0000_0200});
        check_val("sim_starve0", dut.u_starve_ctr.r_count, 0);
        serve(1, 32'h0000_00BB);
        check_val("sim_i_rdata", {bus.i_done, bus.i_rdata}, {1'b1, 32'h0000_00BB});
        bus.i_req = 1'b0;
        tick();

        // Starvation: D,D,D,D,I,D with both requests held
        bus.i_req = 1'b1;  bus.i_addr = c_i_base;
        bus.d_req = 1'b1;  bus.d_addr = c_d_base;
        for (int g = 0; g < 6; g++) begin
            exp_d    = (g != 4);
            exp_addr = exp_d ? c_d_base : c_i_base;
            tick();
            check_val($sformatf("stv_grant%0d", g), bus.m_address, exp_addr);
            serve(1, 32'hC000_0000 + g);
            check_val($sformatf("stv_done%0d", g), {bus.d_done, bus.i_done}, {exp_d, ~exp_d});
            tick();
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();

        // Watchdog on an address the mmu never completes
        bus.d_req = 1'b1;  bus.d_addr = 32'h8000_0010;
        tick();
        check_val("wd_addr", bus.m_address, 32'h8000_0010);
        bus.m_busy = 1'b1;
        seen = 0;
        for (int c = 1; c < c_timeout; c++) begin
            tick();
            if (bus.timeout_err || bus.d_done || !bus.m_rw_req) seen++;
        end
        check_val("wd_early", seen, 0);
        tick();
        check_val("wd_err", {bus.timeout_err, bus.d_done, bus.i_done, bus.m_rw_req}, 4'b1100);
        check_val("wd_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        bus.d_req = 1'b0;
        bus.i_req = 1'b1;  bus.i_addr = 32'h0000_0700;
        tick();
        tick();
        check_val("wd_hold_release", {bus.timeout_err, bus.m_rw_req}, 2'b00);
        bus.m_busy = 1'b0;
        tick();
        tick();
        check_val("wd_next_grant", {bus.m_rw_req, bus.m_address}, {1'b1, 32'h0000_0700});
        serve(1, 32'h0000_0055);
        check_val("wd_next_done", {bus.i_done, bus.i_rdata}, {1'b1, 32'h0000_0055});
        bus.i_req = 1'b0;
        tick();

        // Reset while in GRANT
        bus.i_req = 1'b1;  bus.i_addr = 32'h0000_0600;
        tick();
        check_val("rg_grant", bus.m_rw_req, 1);
        bus.m_busy = 1'b1;
        reset = 1'b1;
        tick();
        check_val("rg_cleared", {bus.m_rw_req, bus.i_done, bus.d_done, bus.timeout_err}, 0);
        check_val("rg_addr", bus.m_address, 0);
        reset = 1'b0;
        bus.m_busy = 1'b0;
        tick();
        check_val("rg_regrant", {bus.m_rw_req, bus.m_address}, {1'b1, 32'h0000_0600});
        serve(1, 32'h0000_0077);
        check_val("rg_done", {bus.i_done, bus.i_rdata}, {1'b1, 32'h0000_0077});
        bus.i_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer in front of the `mmu` port. It shares the single `mmu` request interface between the CPU instruction-fetch path (I) and the load/store path (D). It latches the winning request, holds `rw_req` stable until the `mmu` reports `data_valid`, then returns read data and waits for the `mmu` to go idle. Data accesses have priority, and a starvation counter bounds how long instruction fetch can be held off. A watchdog aborts transactions that hang.

## Interface
- `STARVE_LIMIT`, default 4: consecutive D grants allowed while I is pending before I is forced.
- `TIMEOUT`, default 1023: cycles in GRANT without `m_data_valid` before the transaction is aborted.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `i_req` in 1: instruction-fetch request, held until `i_done`.
- `i_addr` in 32: fetch address. Reads only, size fixed at word (2'h2).
- `i_done` out 1: one-cycle completion pulse.
- `i_rdata` out 32: fetch data, valid while `i_done`=1.
- `d_req` in 1: data request, held until `d_done`.
- `d_rw` in 1: 1 = write.
- `d_addr` in 32: data address.
- `d_wdata` in 32: write data.
- `d_size` in 2: 0 = byte, 1 = half, 2 = word.
- `d_done` out 1: one-cycle completion pulse.
- `d_rdata` out 32: load data, valid while `d_done`=1.
- `m_address` out 32, `m_rw_req` out 1, `m_rw` out 1, `m_write_data` out 32, `m_size` out 2: registered request fields driven to the `mmu`.
- `m_read_data` in 32, `m_data_valid` in 1, `m_busy` in 1: from the `mmu`.
- `timeout_err` out 1: one-cycle pulse on a watchdog abort.

## Operation
- States: IDLE, GRANT, RELEASE.
- **IDLE**
  - Arbitrate between `i_req` and `d_req`.
  - Winner is D if `d_req`=1 and not (`i_req`=1 and `starve_cnt` ≥ `STARVE_LIMIT`). Otherwise the winner is I if `i_req`=1.
  - On a win: latch address/rw/wdata/size into the `m_*` registers, set `m_rw_req`=1, record the owner, go to GRANT.
  - For an I grant, `m_rw`=0 and `m_size`=2.
- **starve_cnt**
  - Increments (saturating at `STARVE_LIMIT`) on each D grant made while `i_req`=1.
  - Clears on every I grant, and on a D grant with `i_req`=0.
- **GRANT**
  - `m_*` outputs are frozen.
  - On `m_data_valid`=1: capture `m_read_data` into the owner's rdata register, pulse the owner's done, clear `m_rw_req`, go to RELEASE.
  - The wdog counter increments each GRANT cycle. On reaching `TIMEOUT`:
    - pulse `timeout_err` and pulse the owner's done with rdata = 32'hDEAD_BEEF;
    - clear `m_rw_req` and go to RELEASE.
- **RELEASE**
  - `m_rw_req`=0.
  - Stay until `m_busy`=0, minimum one cycle, then go to IDLE.
- Requester changes of `*_req`/address during GRANT are ignored; only the latched copy is used.
- The non-owner's done stays 0.
- Requests with `m_address[31]`=1 are forwarded unchanged. The `mmu` never completes them, so the watchdog recovers.
- **Reset**: all outputs 0, `m_*` registers 0, `starve_cnt`=0, wdog=0, state IDLE. Reset mid-transaction drops `m_rw_req` on the next edge with no done pulse.

## Timing
- Request seen high in IDLE at edge k → `m_rw_req`=1 from cycle k+1.
- `m_data_valid` high at edge n → done/rdata high during cycle n+1 (exactly one cycle) and `m_rw_req`=0 from cycle n+1.
- IDLE is reached no earlier than cycle n+2. The earliest next grant puts `m_rw_req` high at n+3.
- Requesters deassert `req` on the edge where they sample done=1. A requester wanting back-to-back access keeps `req`=1 and presents the new address from cycle n+2.
- Simultaneous `i_req`/`d_req` in IDLE: D wins unless the starvation rule applies.
- A request arriving while the arbiter is in GRANT/RELEASE waits and is evaluated in the next IDLE cycle.
- Watchdog: the abort fires `TIMEOUT` cycles after GRANT entry.

## Structure
- Shared package (`mem_pkg`): size encodings SZ_BYTE=2'h0, SZ_HALF=2'h1, SZ_WORD=2'h2; state encodings; owner encoding (OWN_I=0, OWN_D=1); the 32'hDEAD_BEEF abort pattern.
- One natural sub-module: `arb_starve_ctr`, a saturating counter with clear/increment and a `limit_hit` output. The rest is a single FSM plus the output registers.

## Test plan
- **Single D word write**: `d_addr`=32'h0001_0040, `d_wdata`=32'h1234_5678, `d_size`=2. → `m_rw_req` high next cycle with matching fields; `mmu` valid after 4 cycles → `d_done` one cycle; `m_rw_req` low in the same cycle.
- **Single I fetch**: `i_addr`=32'h0000_0100, `m_read_data`=32'h0000_0013. → `i_rdata`=32'h0000_0013 with the `i_done` pulse; `m_rw`=0; `m_size`=2.
- **Simultaneous requests in IDLE**: D granted first; I granted on the following IDLE; `starve_cnt`=1 after the first grant.
- **Starvation**: `d_req` held continuously and `i_req` held, `STARVE_LIMIT`=4. → grants D,D,D,D,I,D,…
- **Watchdog**: `mmu` never asserts valid, `TIMEOUT`=16. → `timeout_err` plus `d_done` with rdata 32'hDEAD_BEEF 16 cycles after GRANT entry, then IDLE once `m_busy`=0.
- **Reset in GRANT**: `reset` asserted mid-transaction. → next cycle all outputs 0, no done pulse; a new `i_req` is granted normally after `reset` deasserts.
